best_weight_ctrl: RTL and testbench
===================================

# best_weight_ctrl

Sequencer that owns the best-weight memory and drives the `training_finish` select of the weight output mux. Each epoch it compares the reported error against the best error so far. On a new best it stalls training and copies the current weights into best-weight memory. When the stop condition is met it asserts `training_finish` and sweeps the best weights out to the consumer.

## Interface
- `BIT_WIDTH`, 32, weight/error magnitude width
- `EXTRA_BIT`, 2, guard bits; error and weight words are `BIT_WIDTH+EXTRA_BIT` wide (W)
- `NUM_WEIGHTS`, 16, weight words per set (≥2)
- `ADDR_WIDTH`, 4, weight address width, ≥ clog2(NUM_WEIGHTS)
- `EPOCH_WIDTH`, 16, epoch counter width
- `MAX_EPOCHS`, 1000, epoch limit (only with `BEST_WEIGHT_EPOCH_LIMIT_EN`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; begins training from IDLE or DONE
- `epoch_done`  in  1  one-cycle pulse; `EPOCH_ERROR` valid
- `EPOCH_ERROR`  in  W  unsigned epoch error
- `ERROR_THRESHOLD`  in  W  unsigned stop threshold, sampled with `epoch_done`
- `train_stall`  out  1  holds training engine
- `copy_rd_addr`  out  ADDR_WIDTH  training-memory read address
- `copy_wr_addr`  out  ADDR_WIDTH  best-memory write address
- `copy_we`  out  1  best-memory write enable
- `training_finish`  out  1  mux select; 1 = best weights
- `out_addr`  out  ADDR_WIDTH  readout address to best memory
- `out_valid`  out  1  readout address valid
- `done`  out  1  readout complete (level)
- `BEST_ERROR`  out  W  best error so far
- `EPOCH_COUNT`  out  EPOCH_WIDTH  epochs completed
- `overrun`  out  1  sticky: `epoch_done` arrived while stalled

## Operation
- States: IDLE, TRAIN, COPY, READOUT, DONE.
- IDLE/DONE + `start` → TRAIN. On entry: `BEST_ERROR` = all ones; `EPOCH_COUNT`, `overrun`, `done`, `training_finish` = 0.
- `start` is ignored in TRAIN, COPY and READOUT.
- In TRAIN, `epoch_done` always increments `EPOCH_COUNT`, saturating at all ones.
- New best = `EPOCH_ERROR < BEST_ERROR` (strict, unsigned). The first epoch is always a new best.
- Stop = `EPOCH_ERROR <= ERROR_THRESHOLD`, or the epoch limit reached (see Configuration).
- New best → `BEST_ERROR` ← `EPOCH_ERROR`, then go to COPY. The stop decision is registered and acted on when COPY ends.
- Stop without new best → READOUT.
- COPY: `train_stall` = 1. Reads addresses 0..NUM_WEIGHTS-1 and writes each one a cycle later. Exits to READOUT if stop was pending, else to TRAIN.
- READOUT: `training_finish` = 1, `out_addr` sweeps 0..NUM_WEIGHTS-1 with `out_valid` = 1, then go to DONE.
- DONE: `training_finish` = 1, `done` = 1, `train_stall` = 1; both held until `start`.
- `epoch_done` in COPY, READOUT or DONE is ignored for error and count, and sets `overrun`.
- `epoch_done` in IDLE is ignored and does not set `overrun`.

## Timing
- All outputs are registered. Reset values are all 0, except `BEST_ERROR` = all ones.
- Reset asserted mid-operation aborts immediately to IDLE. No partial copy resumes.
- `epoch_done` at edge t → `EPOCH_COUNT`/`BEST_ERROR` update at t+1. COPY or READOUT outputs begin at t+1.
- COPY lasts NUM_WEIGHTS+1 cycles:
  - `copy_rd_addr` = k in cycle k (0..NUM_WEIGHTS-1).
  - `copy_we` = 1 in cycles 1..NUM_WEIGHTS, with `copy_wr_addr` = k-1.
  - Training-memory read latency is one cycle.
- `train_stall` is high for exactly the COPY cycles, plus all of READOUT and DONE.
- READOUT lasts NUM_WEIGHTS cycles. `done` rises the cycle after the last `out_valid`.
- Address counters stop at NUM_WEIGHTS-1 and never wrap past it. They reset to 0 on each COPY or READOUT entry.

## Configuration
- `BEST_WEIGHT_EPOCH_LIMIT_EN` defined: the stop condition also includes `EPOCH_COUNT` reaching `MAX_EPOCHS` (post-increment value == `MAX_EPOCHS`).
- Not defined: only the threshold terminates training. `MAX_EPOCHS` is unused and `EPOCH_COUNT` saturates.

## Test plan
- NUM_WEIGHTS=16, threshold 10; errors 100, 50, 70, 8:
  - copies after epochs 1, 2 and 4; none after epoch 3.
  - `BEST_ERROR` = 8; after the last copy → READOUT with `out_addr` 0..15, then `done`.
- Single COPY: `copy_rd_addr` 0..15 in cycles 0..15; `copy_we` in cycles 1..16 with `copy_wr_addr` = rd-1; `train_stall` high 17 cycles.
- Threshold 60, errors 100, 80 (new best, above threshold), 60:
  - 60 is both a new best and the stop: full COPY first, then READOUT.
  - `training_finish` rises the first READOUT cycle.
- `BEST_WEIGHT_EPOCH_LIMIT_EN`, MAX_EPOCHS=3, threshold 0, errors 9, 9, 9:
  - one copy only (equal error is not a new best).
  - finish after the 3rd epoch, `EPOCH_COUNT` = 3.
- `epoch_done` injected mid-COPY → `overrun` = 1, `EPOCH_COUNT` unchanged.
- `rst_n` low mid-READOUT → all outputs 0, `BEST_ERROR` = all ones, state IDLE.
- `start` in DONE → TRAIN, with `training_finish` and `done` = 0 the next cycle.

Source files
------------

// File: rtl/best_weight_ctrl.sv
// Best-weight sequencer: tracks best epoch error, copies weights on a new best, sweeps them out at finish.
// Optional macro BEST_WEIGHT_EPOCH_LIMIT_EN adds "EPOCH_COUNT reached MAX_EPOCHS" to the stop condition.
module best_weight_ctrl #(
  parameter int BIT_WIDTH   = 32,
  parameter int EXTRA_BIT   = 2,
  parameter int NUM_WEIGHTS = 16,
  parameter int ADDR_WIDTH  = 4,
  parameter int EPOCH_WIDTH = 16,
  parameter int MAX_EPOCHS  = 1000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           epoch_done,
  input  logic [BIT_WIDTH+EXTRA_BIT-1:0] EPOCH_ERROR,
  input  logic [BIT_WIDTH+EXTRA_BIT-1:0] ERROR_THRESHOLD,
  output logic                           train_stall,
  output logic [ADDR_WIDTH-1:0]          copy_rd_addr,
  output logic [ADDR_WIDTH-1:0]          copy_wr_addr,
  output logic                           copy_we,
  output logic                           training_finish,
  output logic [ADDR_WIDTH-1:0]          out_addr,
  output logic                           out_valid,
  output logic                           done,
  output logic [BIT_WIDTH+EXTRA_BIT-1:0] BEST_ERROR,
  output logic [EPOCH_WIDTH-1:0]         EPOCH_COUNT,
  output logic                           overrun
);

  localparam int W  = BIT_WIDTH + EXTRA_BIT;
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR   = ADDR_WIDTH'(NUM_WEIGHTS - 1);
  localparam logic [CW-1:0]          COPY_LAST   = CW'(NUM_WEIGHTS);
  localparam logic [EPOCH_WIDTH-1:0] EPOCH_LIMIT = EPOCH_WIDTH'(MAX_EPOCHS);

  typedef enum logic [2:0] {S_IDLE, S_TRAIN, S_COPY, S_READOUT, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [W-1:0]           best_q, best_d;
  logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
  logic                   overrun_q, overrun_d;
  logic                   stop_pend_q, stop_pend_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
  logic                   out_valid_q, out_valid_d;
  logic                   stall_q, stall_d;
  logic                   finish_q, finish_d;
  logic                   done_q, done_d;

  logic [EPOCH_WIDTH-1:0] epoch_inc;
  logic                   new_best;
  logic                   stop_now;
  logic                   go_train;
  logic                   go_readout;

  assign epoch_inc = (&epoch_q) ? epoch_q : epoch_q + EPOCH_WIDTH'(1);
  // A cleared counter marks the first epoch, which must win even against an all-ones error.
  assign new_best  = (epoch_q == '0) || (EPOCH_ERROR < best_q);

`ifdef BEST_WEIGHT_EPOCH_LIMIT_EN
  assign stop_now = (EPOCH_ERROR <= ERROR_THRESHOLD) || (epoch_inc == EPOCH_LIMIT);
`else
  logic unused_epoch_limit;
  assign unused_epoch_limit = ^EPOCH_LIMIT;
  assign stop_now = (EPOCH_ERROR <= ERROR_THRESHOLD);
`endif

  always_comb begin
    state_d     = state_q;
    best_d      = best_q;
    epoch_d     = epoch_q;
    overrun_d   = overrun_q;
    stop_pend_d = stop_pend_q;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    we_d        = we_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    stall_d     = stall_q;
    finish_d    = finish_q;
    done_d      = done_q;
    go_train    = 1'b0;
    go_readout  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) go_train = 1'b1;
      end
      S_TRAIN: begin
        if (epoch_done) begin
          epoch_d = epoch_inc;
          if (new_best) begin
            best_d      = EPOCH_ERROR;
            stop_pend_d = stop_now;
            state_d     = S_COPY;
            stall_d     = 1'b1;
            cnt_d       = '0;
            rd_addr_d   = '0;
            wr_addr_d   = '0;
            we_d        = 1'b0;
          end else if (stop_now) begin
            go_readout = 1'b1;
          end
        end
      end
      S_COPY: begin
        if (epoch_done) overrun_d = 1'b1;
        if (cnt_q == COPY_LAST) begin
          we_d = 1'b0;
          if (stop_pend_q) begin
            go_readout = 1'b1;
          end else begin
            state_d = S_TRAIN;
            stall_d = 1'b0;
          end
        end else begin
          // Write trails read by one cycle to cover the training-memory read latency.
          cnt_d     = cnt_q + CW'(1);
          rd_addr_d = (rd_addr_q == LAST_ADDR) ? rd_addr_q : rd_addr_q + ADDR_WIDTH'(1);
          wr_addr_d = rd_addr_q;
          we_d      = 1'b1;
        end
      end
      S_READOUT: begin
        if (epoch_done) overrun_d = 1'b1;
        if (out_addr_q == LAST_ADDR) begin
          state_d     = S_DONE;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end else begin
          out_addr_d = out_addr_q + ADDR_WIDTH'(1);
        end
      end
      S_DONE: begin
        if (start)           go_train  = 1'b1;
        else if (epoch_done) overrun_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_train) begin
      state_d     = S_TRAIN;
      best_d      = '1;
      epoch_d     = '0;
      overrun_d   = 1'b0;
      stop_pend_d = 1'b0;
      done_d      = 1'b0;
      finish_d    = 1'b0;
      stall_d     = 1'b0;
      out_valid_d = 1'b0;
      we_d        = 1'b0;
    end

    if (go_readout) begin
      state_d     = S_READOUT;
      finish_d    = 1'b1;
      stall_d     = 1'b1;
      out_addr_d  = '0;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      best_q      <= '1;
      epoch_q     <= '0;
      overrun_q   <= 1'b0;
      stop_pend_q <= 1'b0;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      we_q        <= 1'b0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      finish_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      best_q      <= best_d;
      epoch_q     <= epoch_d;
      overrun_q   <= overrun_d;
      stop_pend_q <= stop_pend_d;
      cnt_q       <= cnt_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      we_q        <= we_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
      finish_q    <= finish_d;
      done_q      <= done_d;
    end
  end

  assign train_stall     = stall_q;
  assign copy_rd_addr    = rd_addr_q;
  assign copy_wr_addr    = wr_addr_q;
  assign copy_we         = we_q;
  assign training_finish = finish_q;
  assign out_addr        = out_addr_q;
  assign out_valid       = out_valid_q;
  assign done            = done_q;
  assign BEST_ERROR      = best_q;
  assign EPOCH_COUNT     = epoch_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_best_weight_ctrl.sv
// Directed bench for best_weight_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_best_weight_ctrl;

  localparam int BW = 32;
  localparam int EB = 2;
  localparam int W  = BW + EB;
  localparam int NW = 16;
  localparam int AW = 4;
  localparam int EW = 16;
  localparam logic [63:0] ALL1 = (64'd1 << W) - 64'd1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          epoch_done;
  logic [W-1:0]  EPOCH_ERROR;
  logic [W-1:0]  ERROR_THRESHOLD;
  logic          train_stall;
  logic [AW-1:0] copy_rd_addr;
  logic [AW-1:0] copy_wr_addr;
  logic          copy_we;
  logic          training_finish;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          done;
  logic [W-1:0]  BEST_ERROR;
  logic [EW-1:0] EPOCH_COUNT;
  logic          overrun;

  best_weight_ctrl #(
    .BIT_WIDTH(BW), .EXTRA_BIT(EB), .NUM_WEIGHTS(NW),
    .ADDR_WIDTH(AW), .EPOCH_WIDTH(EW), .MAX_EPOCHS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .epoch_done(epoch_done),
    .EPOCH_ERROR(EPOCH_ERROR), .ERROR_THRESHOLD(ERROR_THRESHOLD),
    .train_stall(train_stall), .copy_rd_addr(copy_rd_addr),
    .copy_wr_addr(copy_wr_addr), .copy_we(copy_we),
    .training_finish(training_finish), .out_addr(out_addr),
    .out_valid(out_valid), .done(done), .BEST_ERROR(BEST_ERROR),
    .EPOCH_COUNT(EPOCH_COUNT), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic epoch(input logic [W-1:0] err);
    EPOCH_ERROR = err;
    epoch_done  = 1'b1;
    @(negedge clk);
    epoch_done  = 1'b0;
  endtask

  // Entered at COPY cycle 0; leaves at the first cycle after COPY.
  task automatic copy_check();
    for (int k = 0; k <= NW; k++) begin
      chk("copy_rd", copy_rd_addr, (k < NW) ? k : NW - 1);
      chk("copy_we", copy_we, (k >= 1) ? 1 : 0);
      if (k >= 1) chk("copy_wr", copy_wr_addr, k - 1);
      chk("copy_stall", train_stall, 1);
      chk("copy_finish", training_finish, 0);
      @(negedge clk);
    end
  endtask

  // Entered at READOUT cycle 0; leaves at the first DONE cycle.
  task automatic readout_check();
    for (int j = 0; j < NW; j++) begin
      chk("ro_valid", out_valid, 1);
      chk("ro_addr", out_addr, j);
      chk("ro_finish", training_finish, 1);
      chk("ro_stall", train_stall, 1);
      chk("ro_done", done, 0);
      @(negedge clk);
    end
    chk("done_lvl", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_finish", training_finish, 1);
    chk("done_stall", train_stall, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; epoch_done = 1'b0;
    EPOCH_ERROR = '0; ERROR_THRESHOLD = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", train_stall, 0);
    chk("rst_best", BEST_ERROR, ALL1);
    chk("rst_count", EPOCH_COUNT, 0);
    chk("rst_finish", training_finish, 0);
    chk("rst_done", done, 0);
    chk("rst_we", copy_we, 0);
    chk("rst_valid", out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Threshold 10, errors 100, 50, 70, 8.
    ERROR_THRESHOLD = 10;
    do_start();
    chk("a_start_stall", train_stall, 0);
    epoch(100);
    copy_check();
    chk("a1_resume", train_stall, 0);
    chk("a1_best", BEST_ERROR, 100);
    chk("a1_count", EPOCH_COUNT, 1);
    epoch(50);
    copy_check();
    chk("a2_best", BEST_ERROR, 50);
    epoch(70);
    chk("a3_nocopy", train_stall, 0);
    chk("a3_we", copy_we, 0);
    chk("a3_best", BEST_ERROR, 50);
    chk("a3_count", EPOCH_COUNT, 3);
    epoch(8);
    copy_check();
    readout_check();
    chk("a4_best", BEST_ERROR, 8);
    chk("a4_count", EPOCH_COUNT, 4);
    chk("a4_overrun", overrun, 0);
    repeat (3) @(negedge clk);
    chk("a_done_hold", done, 1);

    // start in DONE restarts training.
    do_start();
    chk("b_finish", training_finish, 0);
    chk("b_done", done, 0);
    chk("b_stall", train_stall, 0);
    chk("b_best", BEST_ERROR, ALL1);
    chk("b_count", EPOCH_COUNT, 0);

    // Threshold 60, errors 100, 80, 60: last one is new best and stop.
    ERROR_THRESHOLD = 60;
    epoch(100);
    copy_check();
    epoch(80);
    copy_check();
    chk("c2_resume", train_stall, 0);
    epoch(60);
    copy_check();
    readout_check();
    chk("c_best", BEST_ERROR, 60);
    chk("c_count", EPOCH_COUNT, 3);

    // epoch_done mid-COPY sets overrun only.
    do_start();
    ERROR_THRESHOLD = 10;
    epoch(100);
    repeat (3) @(negedge clk);
    EPOCH_ERROR = 5;
    epoch_done  = 1'b1;
    @(negedge clk);
    epoch_done  = 1'b0;
    chk("d_overrun", overrun, 1);
    chk("d_count", EPOCH_COUNT, 1);
    chk("d_best", BEST_ERROR, 100);
    repeat (13) @(negedge clk);
    chk("d_resume", train_stall, 0);
    chk("d_sticky", overrun, 1);
    epoch(200);
    chk("d_worse_stall", train_stall, 0);
    chk("d_worse_count", EPOCH_COUNT, 2);

    // Reset mid-READOUT.
    epoch(7);
    repeat (NW + 1) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("e_ro_valid", out_valid, 1);
    chk("e_ro_addr", out_addr, 5);
    rst_n = 1'b0;
    #1;
    chk("e_rst_stall", train_stall, 0);
    chk("e_rst_finish", training_finish, 0);
    chk("e_rst_valid", out_valid, 0);
    chk("e_rst_addr", out_addr, 0);
    chk("e_rst_best", BEST_ERROR, ALL1);
    chk("e_rst_count", EPOCH_COUNT, 0);
    chk("e_rst_overrun", overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    epoch(3);
    chk("e_idle_count", EPOCH_COUNT, 0);
    chk("e_idle_overrun", overrun, 0);
    chk("e_idle_stall", train_stall, 0);
    chk("e_idle_best", BEST_ERROR, ALL1);

    // Threshold 0, errors 9, 9, 9: equal error is not a new best.
    do_start();
    ERROR_THRESHOLD = 0;
    epoch(9);
    copy_check();
    chk("f1_resume", train_stall, 0);
    epoch(9);
    chk("f2_nocopy", train_stall, 0);
    chk("f2_count", EPOCH_COUNT, 2);
    epoch(9);
    chk("f3_count", EPOCH_COUNT, 3);
`ifdef BEST_WEIGHT_EPOCH_LIMIT_EN
    chk("f3_stall", train_stall, 1);
    chk("f3_finish", training_finish, 1);
    chk("f3_valid", out_valid, 1);
    chk("f3_addr", out_addr, 0);
`else
    chk("f3_stall", train_stall, 0);
    chk("f3_finish", training_finish, 0);
`endif
    chk("f3_best", BEST_ERROR, 9);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
